// File: rtl/dqs_train_pkg.sv
// Shared types and constants for the DQS gate training sequencer.
package dqs_train_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_STEP,
    S_CHECK,
    S_CENTER,
    S_FAIL
  } train_state_e;

  typedef enum logic [2:0] {
    P_IDLE,
    P_LOAD,
    P_SETUP,
    P_MOVE,
    P_GAP,
    P_DONE
  } pulse_state_e;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_NOPASS = 2'b01;
  localparam logic [1:0] ERR_NARROW = 2'b10;
  localparam logic [1:0] ERR_OOR    = 2'b11;

endpackage

// File: rtl/dqs_move_pulser.sv
// Delay-line command pulser: optional LOAD, then move_cnt MOVE pulses with
// DIRECTION set up one cycle ahead and MOVE_GAP idle cycles between moves.
// A one-cycle done pulse closes each request. MOVE_GAP must be >= 1.
//
// state   | meaning
// P_IDLE  | waiting for a request
// P_LOAD  | LOAD pulse (tap reset to 0)
// P_SETUP | DIRECTION already high, one cycle before the first MOVE
// P_MOVE  | MOVE pulse
// P_GAP   | idle spacing after a MOVE
// P_DONE  | done handshake back to the sequencer
module dqs_move_pulser
  import dqs_train_pkg::*;
#(
  parameter int TAP_W    = 7,
  parameter int MOVE_GAP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             with_load,
  input  logic [TAP_W-1:0] move_cnt,
  output logic             load,
  output logic             move,
  output logic             direction,
  output logic             done
);

  localparam int GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(MOVE_GAP - 1);

  pulse_state_e     state_q, state_d;
  logic [TAP_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             dir_q, dir_d;

  // state, remaining-move count, gap timer and direction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= P_IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      dir_q   <= dir_d;
    end
  end

  // next-state and pulse decode
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    dir_d   = dir_q;
    load    = 1'b0;
    move    = 1'b0;
    done    = 1'b0;
    case (state_q)
      P_IDLE: begin
        if (start) begin
          rem_d = move_cnt;
          if (move_cnt != '0) dir_d = 1'b1;
          if (with_load)             state_d = P_LOAD;
          else if (move_cnt != '0)   state_d = P_SETUP;
          else                       state_d = P_DONE;
        end
      end
      P_LOAD: begin
        load    = 1'b1;
        state_d = (rem_q != '0) ? P_SETUP : P_DONE;
      end
      P_SETUP: state_d = P_MOVE;
      P_MOVE: begin
        move    = 1'b1;
        rem_d   = rem_q - TAP_W'(1);
        gap_d   = GAP_LD;
        state_d = P_GAP;
      end
      P_GAP: begin
        if (gap_q == '0) state_d = (rem_q != '0) ? P_MOVE : P_DONE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      P_DONE: begin
        done    = 1'b1;
        state_d = P_IDLE;
      end
      default: state_d = P_IDLE;
    endcase
  end

  assign direction = dir_q;

endmodule

// File: rtl/dqs_gate_train_ctrl.sv
// Per-lane read-DQS delay training: sweeps the IOD delay line, finds the first
// contiguous passing window and parks the line at its centre.
// Optional build macro DQS_GATE_TRAIN_MAP_EN adds the per-tap PASS_MAP output.
//
// state    | meaning
// S_IDLE   | waiting for START
// S_LOAD   | reload tap 0 before the sweep
// S_CLEAR  | clear eye-monitor flags
// S_SETTLE | wait for the delay line to settle
// S_SAMPLE | accumulate early/late flags
// S_EVAL   | classify tap, update window, decide stop/step
// S_STEP   | move one tap up
// S_CHECK  | judge the found window
// S_CENTER | reload and move to window centre
// S_FAIL   | park at tap 0 and report error
module dqs_gate_train_ctrl
  import dqs_train_pkg::*;
#(
  parameter int TAP_W      = 7,
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLE_CYC = 16,
  parameter int MIN_WIN    = 4,
  parameter int MOVE_GAP   = 2
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             START,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       ERR,
  output logic [TAP_W-1:0] TAP_CUR,
  output logic [TAP_W-1:0] WIN_START,
  output logic [TAP_W-1:0] WIN_END
`ifdef DQS_GATE_TRAIN_MAP_EN
  ,
  output logic [2**TAP_W-1:0] PASS_MAP
`endif
);

  localparam int TMR_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] SAMPLE_LD = TMR_W'(SAMPLE_CYC - 1);
  localparam logic [TAP_W-1:0] TAP_LAST  = {TAP_W{1'b1}};
  localparam logic [TAP_W:0]   MIN_WIN_V = (TAP_W+1)'(MIN_WIN);
  localparam logic [TAP_W:0]   ONE_W     = (TAP_W+1)'(1);

  train_state_e     state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tap_fail_q, tap_fail_d;
  logic             found_q, found_d;
  logic             oor_stop_q, oor_stop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic [TAP_W-1:0] win_start_q, win_start_d;
  logic [TAP_W-1:0] win_end_q, win_end_d;
  logic             req_sent_q, req_sent_d;
  logic [TAP_W-1:0] tap_q;

  logic             pul_start, pul_with_load, pul_load, pul_move, pul_dir, pul_done;
  logic [TAP_W-1:0] pul_cnt;
  logic             clear_flags;
  logic [TAP_W:0]   win_len;
  logic [TAP_W-1:0] target;

`ifdef DQS_GATE_TRAIN_MAP_EN
  logic [2**TAP_W-1:0] pass_map_q, pass_map_d;
`endif

  assign win_len = {1'b0, win_end_q} - {1'b0, win_start_q} + ONE_W;
  assign target  = win_start_q + ((win_end_q - win_start_q) >> 1);

  dqs_move_pulser #(
    .TAP_W    (TAP_W),
    .MOVE_GAP (MOVE_GAP)
  ) u_pulser (
    .clk       (FAB_CLK),
    .rst_n     (ARST_N),
    .start     (pul_start),
    .with_load (pul_with_load),
    .move_cnt  (pul_cnt),
    .load      (pul_load),
    .move      (pul_move),
    .direction (pul_dir),
    .done      (pul_done)
  );

  // sequencer and result registers
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      tap_fail_q  <= 1'b0;
      found_q     <= 1'b0;
      oor_stop_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_NONE;
      win_start_q <= '0;
      win_end_q   <= '0;
      req_sent_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      tap_fail_q  <= tap_fail_d;
      found_q     <= found_d;
      oor_stop_q  <= oor_stop_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      win_start_q <= win_start_d;
      win_end_q   <= win_end_d;
      req_sent_q  <= req_sent_d;
    end
  end

  // tap tracker follows the pulses actually sent to the delay line
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N)       tap_q <= '0;
    else if (pul_load) tap_q <= '0;
    else if (pul_move) tap_q <= tap_q + TAP_W'(1);
  end

`ifdef DQS_GATE_TRAIN_MAP_EN
  // per-tap pass record
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) pass_map_q <= '0;
    else         pass_map_q <= pass_map_d;
  end
  assign PASS_MAP = pass_map_q;
`endif

  // next-state, timers, window bookkeeping and pulser requests
  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    tap_fail_d    = tap_fail_q;
    found_d       = found_q;
    oor_stop_d    = oor_stop_q;
    busy_d        = busy_q;
    done_d        = done_q;
    err_d         = err_q;
    win_start_d   = win_start_q;
    win_end_d     = win_end_q;
    req_sent_d    = req_sent_q;
    pul_start     = 1'b0;
    pul_with_load = 1'b0;
    pul_cnt       = '0;
    clear_flags   = 1'b0;
`ifdef DQS_GATE_TRAIN_MAP_EN
    pass_map_d    = pass_map_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = ERR_NONE;
          win_start_d = '0;
          win_end_d   = '0;
          found_d     = 1'b0;
          oor_stop_d  = 1'b0;
`ifdef DQS_GATE_TRAIN_MAP_EN
          pass_map_d  = '0;
`endif
          state_d     = S_LOAD;
        end
      end
      S_LOAD, S_STEP, S_CENTER, S_FAIL: begin
        pul_with_load = (state_q != S_STEP);
        pul_cnt       = (state_q == S_STEP)   ? TAP_W'(1) :
                        (state_q == S_CENTER) ? target    : '0;
        pul_start     = !req_sent_q;
        if (!req_sent_q) req_sent_d = 1'b1;
        if (pul_done) begin
          req_sent_d = 1'b0;
          case (state_q)
            S_LOAD, S_STEP: state_d = S_CLEAR;
            S_CENTER: begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
            default: begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          endcase
        end
      end
      S_CLEAR: begin
        clear_flags = 1'b1;
        tmr_d       = SETTLE_LD;
        state_d     = S_SETTLE;
      end
      S_SETTLE: begin
        if (tmr_q == '0) begin
          tmr_d      = SAMPLE_LD;
          tap_fail_d = 1'b0;
          state_d    = S_SAMPLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_SAMPLE: begin
        tap_fail_d = tap_fail_q | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
        if (tmr_q == '0) state_d = S_EVAL;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      S_EVAL: begin
        if (!tap_fail_q) begin
          if (!found_q) begin
            found_d     = 1'b1;
            win_start_d = tap_q;
          end
          win_end_d = tap_q;
`ifdef DQS_GATE_TRAIN_MAP_EN
          pass_map_d[tap_q] = 1'b1;
`endif
        end
        if (tap_fail_q && found_q) begin
          state_d = S_CHECK;
        end else if (tap_q == TAP_LAST || DELAY_LINE_OUT_OF_RANGE) begin
          oor_stop_d = DELAY_LINE_OUT_OF_RANGE;
          state_d    = S_CHECK;
        end else begin
          state_d = S_STEP;
        end
      end
      S_CHECK: begin
        if (!found_q) begin
          err_d   = oor_stop_q ? ERR_OOR : ERR_NOPASS;
          state_d = S_FAIL;
        end else if (win_len < MIN_WIN_V) begin
          err_d   = ERR_NARROW;
          state_d = S_FAIL;
        end else begin
          state_d = S_CENTER;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign DELAY_LINE_LOAD         = pul_load;
  assign DELAY_LINE_MOVE         = pul_move;
  assign DELAY_LINE_DIRECTION    = pul_dir;
  assign EYE_MONITOR_CLEAR_FLAGS = clear_flags;
  assign BUSY                    = busy_q;
  assign DONE                    = done_q;
  assign ERR                     = err_q;
  assign TAP_CUR                 = tap_q;
  assign WIN_START               = win_start_q;
  assign WIN_END                 = win_end_q;

endmodule
